// File: rtl/sw_debounce_if.sv
// Switch conditioning bundle: raw pins in, debounced levels and edge strobes out.
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_pin;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  // Switch side: drives raw pins, observes conditioned outputs.
  modport master (
    output sw_raw,
    input  sw_pin,
    input  sw_rise,
    input  sw_fall
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    output sw_pin,
    output sw_rise,
    output sw_fall
  );
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchroniser plus per-bit stability counter for slide
// switches. A new level is accepted only after CNT_MAX consecutive cycles of
// disagreement with the current level; any return clears the count.
// Optional macro SW_DEBOUNCE_EDGE_EN compiles in registered rise/fall strobes;
// without it sw_rise/sw_fall are tied to 0.
module sw_debounce #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_MAX = 1000000
) (
  input logic          sys_clk_in,
  input logic          sys_rst_n,
  sw_debounce_if.slave sw
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] pin_q;
  logic [WIDTH-1:0] pin_nxt;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  // Per-bit stability counter and level acceptance.
  always_comb begin
    pin_nxt = pin_q;
    cnt_nxt = '{default: '0};
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2[i] != pin_q[i]) begin
        if (cnt[i] == CNT_LAST) begin
          pin_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser, counters and stable level registers.
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1    <= '0;
      s2    <= '0;
      pin_q <= '0;
      cnt   <= '{default: '0};
    end else begin
      s1    <= sw.sw_raw;
      s2    <= s1;
      pin_q <= pin_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign sw.sw_pin = pin_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Strobes register alongside pin_q so they coincide with the new level.
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= pin_nxt & ~pin_q;
      fall_q <= ~pin_nxt & pin_q;
    end
  end

  assign sw.sw_rise = rise_q;
  assign sw.sw_fall = fall_q;
`else
  assign sw.sw_rise = '0;
  assign sw.sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed self-checking bench for sw_debounce with CNT_MAX=4, WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sw_debounce;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned CNT_MAX = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  sw_debounce_if #(.WIDTH(WIDTH)) sw ();

  sw_debounce #(
    .WIDTH  (WIDTH),
    .CNT_MAX(CNT_MAX)
  ) dut (
    .sys_clk_in(clk),
    .sys_rst_n (rst_n),
    .sw        (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] exp_pin;
    logic [7:0] exp_rise;
    rst_n     = 1'b0;
    sw.sw_raw = 8'h00;
    repeat (3) step();
    rst_n     = 1'b1;
    sw.sw_raw = 8'hFF;
    repeat (8) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (sw.sw_pin !== 8'h00) $display("FAIL reset_pin: got %h want 00", sw.sw_pin);
    else n_pass++;
    n_total++;
    if (sw.sw_rise !== 8'h00) $display("FAIL reset_rise: got %h want 00", sw.sw_rise);
    else n_pass++;
    n_total++;
    if (sw.sw_fall !== 8'h00) $display("FAIL reset_fall: got %h want 00", sw.sw_fall);
    else n_pass++;
    step();
    sw.sw_raw = 8'h01;
    rst_n     = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_pin  = (k >= 6) ? 8'h01 : 8'h00;
      exp_rise = (EDGE_EN && k == 6) ? 8'h01 : 8'h00;
      n_total++;
      if (sw.sw_pin !== exp_pin) $display("FAIL latency_pin step %0d: got %h want %h", k, sw.sw_pin, exp_pin);
      else n_pass++;
      n_total++;
      if (sw.sw_rise !== exp_rise) $display("FAIL latency_rise step %0d: got %h want %h", k, sw.sw_rise, exp_rise);
      else n_pass++;
      n_total++;
      if (sw.sw_fall !== 8'h00) $display("FAIL latency_fall step %0d: got %h want 00", k, sw.sw_fall);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_pin;
    logic [7:0] exp_rise;
    for (int p = 0; p < 4; p++) begin
      sw.sw_raw = (p % 2 == 0) ? 8'h09 : 8'h01;
      for (int k = 0; k < 3; k++) begin
        step();
        n_total++;
        if (sw.sw_pin !== 8'h01) $display("FAIL bounce_pin phase %0d: got %h want 01", p, sw.sw_pin);
        else n_pass++;
        n_total++;
        if ((sw.sw_rise | sw.sw_fall) !== 8'h00)
          $display("FAIL bounce_strobe phase %0d: got rise %h fall %h want 00", p, sw.sw_rise, sw.sw_fall);
        else n_pass++;
      end
    end
    sw.sw_raw = 8'h09;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_pin  = (k >= 6) ? 8'h09 : 8'h01;
      exp_rise = (EDGE_EN && k == 6) ? 8'h08 : 8'h00;
      n_total++;
      if (sw.sw_pin !== exp_pin) $display("FAIL bounce_hold_pin step %0d: got %h want %h", k, sw.sw_pin, exp_pin);
      else n_pass++;
      n_total++;
      if (sw.sw_rise !== exp_rise) $display("FAIL bounce_hold_rise step %0d: got %h want %h", k, sw.sw_rise, exp_rise);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [7:0] exp_pin;
    logic [7:0] exp_fall;
    sw.sw_raw = 8'hFF;
    repeat (8) step();
    n_total++;
    if (sw.sw_pin !== 8'hFF) $display("FAIL release_setup: got %h want ff", sw.sw_pin);
    else n_pass++;
    sw.sw_raw = 8'h00;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_pin  = (k >= 6) ? 8'h00 : 8'hFF;
      exp_fall = (EDGE_EN && k == 6) ? 8'hFF : 8'h00;
      n_total++;
      if (sw.sw_pin !== exp_pin) $display("FAIL release_pin step %0d: got %h want %h", k, sw.sw_pin, exp_pin);
      else n_pass++;
      n_total++;
      if (sw.sw_fall !== exp_fall) $display("FAIL release_fall step %0d: got %h want %h", k, sw.sw_fall, exp_fall);
      else n_pass++;
      n_total++;
      if (sw.sw_rise !== 8'h00) $display("FAIL release_rise step %0d: got %h want 00", k, sw.sw_rise);
      else n_pass++;
    end
  endtask

  task automatic test_independence();
    logic [7:0] exp_pin;
    logic [7:0] exp_rise;
    sw.sw_raw = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_pin  = (k >= 8) ? 8'h81 : (k >= 6) ? 8'h01 : 8'h00;
      exp_rise = !EDGE_EN ? 8'h00 : (k == 6) ? 8'h01 : (k == 8) ? 8'h80 : 8'h00;
      n_total++;
      if (sw.sw_pin !== exp_pin) $display("FAIL indep_pin step %0d: got %h want %h", k, sw.sw_pin, exp_pin);
      else n_pass++;
      n_total++;
      if (sw.sw_rise !== exp_rise) $display("FAIL indep_rise step %0d: got %h want %h", k, sw.sw_rise, exp_rise);
      else n_pass++;
      if (k == 2) sw.sw_raw = 8'h81;
    end
  endtask

  task automatic test_reset_midcount();
    logic [7:0] exp_pin;
    logic [7:0] exp_rise;
    sw.sw_raw = 8'h00;
    repeat (8) step();
    sw.sw_raw = 8'h04;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_total++;
      if (sw.sw_pin !== 8'h00) $display("FAIL midcount_pre step %0d: got %h want 00", k, sw.sw_pin);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if (sw.sw_pin !== 8'h00) $display("FAIL midcount_in_reset: got %h want 00", sw.sw_pin);
    else n_pass++;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_pin  = (k >= 6) ? 8'h04 : 8'h00;
      exp_rise = (EDGE_EN && k == 6) ? 8'h04 : 8'h00;
      n_total++;
      if (sw.sw_pin !== exp_pin) $display("FAIL midcount_pin step %0d: got %h want %h", k, sw.sw_pin, exp_pin);
      else n_pass++;
      n_total++;
      if (sw.sw_rise !== exp_rise) $display("FAIL midcount_rise step %0d: got %h want %h", k, sw.sw_rise, exp_rise);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    sw.sw_raw = 8'h00;
    test_reset();
    test_bounce();
    test_release();
    test_independence();
    test_reset_midcount();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
